// File: rtl/p_acc.sv
// Streaming saturating accumulator: sums a valid/ready stream of products into
// one wider result, closed by in_last or by reaching MAX_LEN elements.

package p_acc_pkg;
  typedef enum logic [1:0] {
    DT_INT  = 2'd0,
    DT_BOOL = 2'd1,
    DT_FIX  = 2'd2,
    DT_FLT  = 2'd3
  } dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic       sgn;
    logic [7:0] prec;
  } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: p_acc_pkg::DT_INT, sgn: 1'b1, prec: 8'd8}
`endif

module p_acc #(
  parameter p_acc_pkg::dconf_t I_CONF = `DEF_DCONF,
  parameter p_acc_pkg::dconf_t O_CONF = `DEF_DCONF,
  parameter int MAX_LEN = 256,
  parameter int I_PREC  = int'(I_CONF.prec),
  parameter int O_PREC  = int'(O_CONF.prec),
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_PREC-1:0] in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [O_PREC-1:0] out,
  output logic [CNT_W-1:0]  cnt,
  output logic              ovf
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam bit SGN = I_CONF.sgn;
  localparam logic [O_PREC-1:0] UMAX = '1;
  localparam logic [O_PREC-1:0] SMAX = UMAX >> 1;
  localparam logic [O_PREC-1:0] SMIN = ~SMAX;
  localparam logic [CNT_W-1:0]  LEN_LAST = CNT_W'(MAX_LEN);

  logic [0:0]        state;
  logic [O_PREC-1:0] acc;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  logic [O_PREC:0]   in_ext;
  logic [O_PREC:0]   acc_ext;
  logic [O_PREC:0]   sum;
  logic [O_PREC-1:0] sat_val;
  logic              clip;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;

  // Handshake flags come from the state register alone.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + 1'b1;

  assign out = acc;
  assign cnt = cnt_q;
  assign ovf = ovf_q;

  // One guard bit above O_PREC exposes any overflow of the running sum.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    in_ext  = '0;
    acc_ext = '0;
    sum     = '0;
    sat_val = '0;
    clip    = 1'b0;
    if (SGN) begin
      in_ext  = {{(O_PREC + 1 - I_PREC){in[I_PREC-1]}}, in};
      acc_ext = {acc[O_PREC-1], acc};
    end else begin
      in_ext  = {{(O_PREC + 1 - I_PREC){1'b0}}, in};
      acc_ext = {1'b0, acc};
    end
    sum = acc_ext + in_ext;
    if (SGN) begin
      clip    = sum[O_PREC] ^ sum[O_PREC-1];
      sat_val = clip ? (sum[O_PREC] ? SMIN : SMAX) : sum[O_PREC-1:0];
    end else begin
      clip    = sum[O_PREC];
      sat_val = clip ? UMAX : sum[O_PREC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc   <= sat_val;
            cnt_q <= cnt_inc;
            if (clip) ovf_q <= 1'b1;
            if (in_last || (cnt_inc == LEN_LAST)) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_p_acc.sv
// Bench for p_acc: directed scenarios plus a randomized run, all compared
// against a cycle-level arithmetic model of the accumulator.

module tb_p_acc;
  import p_acc_pkg::*;

  localparam dconf_t I_CONF = '{dtype: DT_INT, sgn: 1'b1, prec: 8'd8};
  localparam dconf_t O_CONF = '{dtype: DT_INT, sgn: 1'b1, prec: 8'd12};
  localparam int OMAX = 2047;
  localparam int OMIN = -2048;
  localparam int LEN  = 256;

  logic        clk = 1'b0;
  logic        reset_;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, ovf;
  logic [7:0]  in_d;
  logic [11:0] out_d;
  logic [8:0]  cnt;

  logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, ovf4;
  logic [7:0]  in_d4;
  logic [11:0] out_d4;
  logic [2:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  int m_acc;
  int m_cnt;
  bit m_ovf;
  bit m_hold;

  always #5 clk = ~clk;

  p_acc #(.I_CONF(I_CONF), .O_CONF(O_CONF), .MAX_LEN(LEN)) dut (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_d), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_d), .cnt(cnt), .ovf(ovf)
  );

  p_acc #(.I_CONF(I_CONF), .O_CONF(O_CONF), .MAX_LEN(4)) dut4 (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid4), .in_ready(in_ready4), .in(in_d4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out_d4), .cnt(cnt4), .ovf(ovf4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/out"}, $signed(out_d), m_acc);
    check({tag, "/cnt"}, int'(cnt), m_cnt);
    check({tag, "/ovf"}, int'(ovf), int'(m_ovf));
    check({tag, "/in_ready"}, int'(in_ready), int'(!m_hold));
    check({tag, "/out_valid"}, int'(out_valid), int'(m_hold));
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check after the edge.
  task automatic cyc(input bit v, input int val, input bit last, input bit ordy, input string tag);
    int s;
    in_valid  = v;
    in_d      = val[7:0];
    in_last   = last;
    out_ready = ordy;
    @(posedge clk);
    if (!m_hold) begin
      if (v) begin
        s = m_acc + val;
        if (s > OMAX) begin
          s = OMAX;
          m_ovf = 1'b1;
        end else if (s < OMIN) begin
          s = OMIN;
          m_ovf = 1'b1;
        end
        m_acc = s;
        m_cnt++;
        if (last || m_cnt == LEN) m_hold = 1'b1;
      end
    end else if (ordy) begin
      model_reset();
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int val;
    int mode;
    reset_     = 1'b0;
    in_valid   = 1'b0;
    in_d       = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    in_d4      = '0;
    in_last4   = 1'b0;
    out_ready4 = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    compare_all("reset");
    check("reset4/in_ready", int'(in_ready4), 1);
    check("reset4/out_valid", int'(out_valid4), 0);
    reset_ = 1'b1;
    @(negedge clk);

    // Implicit end at MAX_LEN=4
    for (int i = 1; i <= 4; i++) begin
      in_valid4 = 1'b1;
      in_d4     = 8'(i);
      @(posedge clk);
      @(negedge clk);
      if (i < 4) check("implicit/in_ready_mid", int'(in_ready4), 1);
    end
    in_valid4 = 1'b0;
    check("implicit/out_valid", int'(out_valid4), 1);
    check("implicit/in_ready", int'(in_ready4), 0);
    check("implicit/out", int'(out_d4), 10);
    check("implicit/cnt", int'(cnt4), 4);
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    check("implicit/rearm", int'(in_ready4), 1);
    check("implicit/clear", int'(out_d4), 0);

    // Basic sum
    cyc(1, 3, 0, 0, "basic1");
    cyc(1, -5, 0, 0, "basic2");
    cyc(1, 10, 1, 0, "basic3");
    check("basic/out_valid", int'(out_valid), 1);
    check("basic/out", $signed(out_d), 8);
    check("basic/cnt", int'(cnt), 3);
    check("basic/ovf", int'(ovf), 0);
    cyc(0, 0, 0, 1, "basic_drain");

    // Positive saturation
    for (int i = 0; i < 20; i++) cyc(1, 127, (i == 19), 0, "possat");
    check("possat/out", int'(out_d), 'h7FF);
    check("possat/ovf", int'(ovf), 1);
    check("possat/cnt", int'(cnt), 20);
    cyc(0, 0, 0, 1, "possat_drain");

    // Negative single beat
    cyc(1, -128, 1, 0, "neg");
    check("neg/out", int'(out_d), 'hF80);
    check("neg/ovf", int'(ovf), 0);
    check("neg/cnt", int'(cnt), 1);
    cyc(0, 0, 0, 1, "neg_drain");

    // Backpressure: 7 must not be consumed while HOLD
    cyc(1, -3, 1, 0, "bp_result");
    repeat (5) cyc(1, 7, 0, 0, "bp_hold");
    check("bp/out_stable", $signed(out_d), -3);
    check("bp/in_ready", int'(in_ready), 0);
    cyc(1, 7, 0, 1, "bp_release");
    check("bp/in_ready_after", int'(in_ready), 1);
    check("bp/cnt_after", int'(cnt), 0);
    cyc(1, 7, 1, 0, "bp_seven");
    check("bp/out_seven", $signed(out_d), 7);
    cyc(0, 0, 0, 1, "bp_drain");

    // Full-length stream without last
    for (int i = 0; i < LEN; i++) cyc(1, 1, 0, 0, "maxlen");
    check("maxlen/out_valid", int'(out_valid), 1);
    check("maxlen/cnt", int'(cnt), LEN);
    check("maxlen/out", $signed(out_d), LEN);
    cyc(0, 0, 0, 1, "maxlen_drain");

    // Reset mid-stream
    cyc(1, 50, 0, 0, "rst_a");
    cyc(1, 60, 0, 0, "rst_b");
    reset_   = 1'b0;
    in_valid = 1'b0;
    #2;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    reset_ = 1'b1;
    compare_all("rst_release");
    cyc(1, 5, 1, 0, "rst_after");
    check("rst/out", $signed(out_d), 5);
    cyc(0, 0, 0, 1, "rst_drain");

    // Randomized run; middle blocks bias values toward saturation
    for (int i = 0; i < 2000; i++) begin
      mode = (i / 400) % 3;
      if (mode == 1) val = int'($urandom_range(100, 127));
      else if (mode == 2) val = -int'($urandom_range(100, 128));
      else val = int'($urandom_range(0, 255)) - 128;
      cyc($urandom_range(0, 3) != 0, val,
          (mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 40) == 0),
          $urandom_range(0, 1) == 1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
